imuldiv_mulresp_serializer: RTL and testbench
=============================================

IMULDIV_MULRESP_SERIALIZER -- requirements
Module: imuldiv_mulresp_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of queued 64-bit results; legal values are 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port mulresp_msg_result, input, 64 bits: the product from the upstream multiplier.
REQ-005 SHALL have port mulresp_msg_fn, input, 2 bits: 00 = low word only, 01 = high word only, 10 = low then high, 11 = treated as 10.
REQ-006 SHALL have port mulresp_val, input, 1 bit: the upstream result is valid.
REQ-007 SHALL have port mulresp_rdy, output, 1 bit: the block can accept a result.
REQ-008 SHALL have port wbresp_msg_data, output, 32 bits: the emitted word.
REQ-009 SHALL have port wbresp_msg_last, output, 1 bit: this is the final word of the current result.
REQ-010 SHALL have port wbresp_val, output, 1 bit: the downstream word is valid.
REQ-011 SHALL have port wbresp_rdy, input, 1 bit: the downstream consumer accepts the word.

Function
REQ-012 SHALL store each {result, fn} pair in a circular queue of DEPTH entries, with write pointer, read pointer and occupancy count registers.
REQ-013 SHALL drive mulresp_rdy = (count != DEPTH), from registered state only; it SHALL NOT depend combinationally on wbresp_rdy.
REQ-014 SHALL enqueue at a posedge when mulresp_val && mulresp_rdy, then write the entry at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-015 SHALL drive wbresp_val = (count != 0), with no bypass, so the minimum latency from enqueue to first word valid is 1 cycle.
REQ-016 SHALL keep a word-index register, widx, with two states: WORD0 (widx = 0) and WORD1 (widx = 1).
REQ-017 SHALL select the output word from the head entry as follows:
- fn = 00: data = result[31:0], last = 1.
- fn = 01: data = result[63:32], last = 1.
- fn = 10 or 11, in WORD0: data = result[31:0], last = 0.
- fn = 10 or 11, in WORD1: data = result[63:32], last = 1.
REQ-018 SHALL transfer a word when wbresp_val && wbresp_rdy:
- If last = 0, go WORD0 -> WORD1 and do not pop.
- If last = 1, return to WORD0, pop the head, and increment rd_ptr modulo DEPTH.
REQ-019 SHALL hold wbresp_msg_data and wbresp_msg_last stable while wbresp_val = 1 and wbresp_rdy = 0.
REQ-020 SHALL, on a simultaneous enqueue and pop in the same cycle, leave count unchanged while advancing both pointers; this is legal only when count < DEPTH before the edge.
REQ-021 SHALL, on a simultaneous enqueue and pop when full, perform only the pop, because mulresp_rdy = 0 blocks the enqueue; count decrements.
REQ-022 SHALL wrap pointers from DEPTH-1 to 0; count SHALL never exceed DEPTH nor underflow below 0.
REQ-023 SHALL ignore mulresp_msg_* when mulresp_val = 0 or mulresp_rdy = 0.
REQ-024 SHALL sustain a throughput of one result per cycle for fn 00/01 and one result per two cycles for fn 10/11, when wbresp_rdy is held at 1.

Reset
REQ-025 SHALL, on reset assertion, immediately and asynchronously clear count, wr_ptr, rd_ptr and widx to 0.
REQ-026 SHALL, during and after reset, drive wbresp_val = 0 and mulresp_rdy = 1; queue storage contents are don't-care.
REQ-027 SHALL, on reset mid-operation (including while in WORD1), discard all queued results; no partial word SHALL be emitted after reset deassertion.
REQ-028 SHALL accept a new result in the first cycle after reset deassertion.

Verification
REQ-029 SHALL cover single low: enqueue result = 0x0000000A_FFFFFFF6, fn = 00, with wbresp_rdy = 1 -> next cycle one word 0xFFFFFFF6 with last = 1, then wbresp_val = 0.
REQ-030 SHALL cover pair split: enqueue 0x12345678_9ABCDEF0, fn = 10 -> words 0x9ABCDEF0 (last = 0) then 0x12345678 (last = 1) on consecutive cycles.
REQ-031 SHALL cover backpressure: hold wbresp_rdy = 0 and enqueue DEPTH results -> mulresp_rdy = 0 after the DEPTH-th accept, data held stable; release rdy -> all words emitted in order, with mulresp_rdy = 1 after the first pop.
REQ-032 SHALL cover full plus simultaneous pop: with count = DEPTH, mulresp_val = 1 and the head's last word accepted -> count = DEPTH-1, the new result is not captured that cycle and is captured the next cycle.
REQ-033 SHALL cover reset in WORD1: fn = 10 entry with its low word already accepted, then assert reset -> wbresp_val = 0 at once; after deassertion no high word appears.
REQ-034 SHALL cover fn = 11: enqueue 0xFFFFFFFF_00000001 with fn = 11 -> identical to fn = 10, i.e. 0x00000001 (last = 0) then 0xFFFFFFFF (last = 1).

Source files
------------

// File: rtl/imuldiv_mulresp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : imuldiv_mulresp_serializer
// Purpose  : Queues 64-bit multiplier results and emits them as 32-bit words
//            (low, high, or low-then-high) toward the writeback port.
// Revision : 1.0
// ============================================================================
module imuldiv_mulresp_serializer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mulresp_msg_result,
    input  logic [1:0]  mulresp_msg_fn,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,
    output logic [31:0] wbresp_msg_data,
    output logic        wbresp_msg_last,
    output logic        wbresp_val,
    input  logic        wbresp_rdy
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    typedef enum logic {
        WORD0 = 1'b0,
        WORD1 = 1'b1
    } widx_t;

    logic [63:0]        r_result [DEPTH];
    logic [1:0]         r_fn     [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    widx_t              r_widx;
    widx_t              w_widx_nxt;

    logic [63:0]        w_head_result;
    logic [1:0]         w_head_fn;
    logic               w_enq;
    logic               w_xfer;
    logic               w_pop;

    // Handshake outputs come only from registered occupancy (no bypass).
    assign mulresp_rdy   = (r_count != c_CNT_FULL);
    assign wbresp_val    = (r_count != '0);
    assign w_enq         = mulresp_val && mulresp_rdy;
    assign w_xfer        = wbresp_val && wbresp_rdy;
    assign w_pop         = w_xfer && wbresp_msg_last;
    assign w_head_result = r_result[r_rd_ptr];
    assign w_head_fn     = r_fn[r_rd_ptr];

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_result[r_wr_ptr] <= mulresp_msg_result;
            r_fn[r_wr_ptr]     <= mulresp_msg_fn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_widx <= WORD0;
        end else begin
            r_widx <= w_widx_nxt;
        end
    end

    // fn[1] set (10/11) means a two-word result: low word first, then high.
    always_comb begin
        wbresp_msg_data = w_head_result[31:0];
        wbresp_msg_last = 1'b1;
        w_widx_nxt      = r_widx;
        if (w_head_fn[1]) begin
            if (r_widx == WORD1) begin
                wbresp_msg_data = w_head_result[63:32];
            end else begin
                wbresp_msg_last = 1'b0;
            end
        end else if (w_head_fn[0]) begin
            wbresp_msg_data = w_head_result[63:32];
        end
        if (w_xfer) begin
            w_widx_nxt = wbresp_msg_last ? WORD0 : WORD1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_mulresp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imuldiv_mulresp_serializer
// Purpose  : Scoreboard bench for the multiplier response serializer.
// Revision : 1.0
// ============================================================================
module tb_imuldiv_mulresp_serializer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] mulresp_msg_result = '0;
    logic [1:0]  mulresp_msg_fn = '0;
    logic        mulresp_val = 1'b0;
    logic        mulresp_rdy;
    logic [31:0] wbresp_msg_data;
    logic        wbresp_msg_last;
    logic        wbresp_val;
    logic        wbresp_rdy = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] sb [$];

    imuldiv_mulresp_serializer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .mulresp_msg_result (mulresp_msg_result),
        .mulresp_msg_fn     (mulresp_msg_fn),
        .mulresp_val        (mulresp_val),
        .mulresp_rdy        (mulresp_rdy),
        .wbresp_msg_data    (wbresp_msg_data),
        .wbresp_msg_last    (wbresp_msg_last),
        .wbresp_val         (wbresp_val),
        .wbresp_rdy         (wbresp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic [63:0] r, input logic [1:0] f);
        case (f)
            2'b00:   sb.push_back({1'b1, r[31:0]});
            2'b01:   sb.push_back({1'b1, r[63:32]});
            default: begin
                sb.push_back({1'b0, r[31:0]});
                sb.push_back({1'b1, r[63:32]});
            end
        endcase
    endfunction

    // Sample point sits 3 units after the falling edge, well clear of posedge.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (wbresp_val && wbresp_rdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", 64'({wbresp_msg_last, wbresp_msg_data}), '1);
                    end else begin
                        e = sb.pop_front();
                        chk("word", 64'({wbresp_msg_last, wbresp_msg_data}), 64'(e));
                    end
                end
                if (mulresp_val && mulresp_rdy) begin
                    push_exp(mulresp_msg_result, mulresp_msg_fn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [63:0] r, input logic [1:0] f, output int stalls);
        stalls = 0;
        @(negedge clk);
        mulresp_val        = 1'b1;
        mulresp_msg_result = r;
        mulresp_msg_fn     = f;
        #3;
        while (!mulresp_rdy && stalls < 200) begin
            @(negedge clk);
            #3;
            stalls++;
        end
        if (!mulresp_rdy) chk("send_timeout", 64'(mulresp_rdy), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        mulresp_val = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #3;
        chk("drain_val", 64'(wbresp_val), 64'd0);
    endtask

    initial begin
        int          st;
        bit          acc;
        logic [63:0] v [DEPTH];

        repeat (3) @(negedge clk);
        #3;
        chk("rst_wbval", 64'(wbresp_val), 64'd0);
        chk("rst_mulrdy", 64'(mulresp_rdy), 64'd1);
        @(negedge clk);
        reset      = 1'b0;
        wbresp_rdy = 1'b1;

        // Single low word
        send(64'h0000000A_FFFFFFF6, 2'b00, st);
        chk("low_stall", 64'(st), 64'd0);
        idle();
        #3;
        chk("low_val", 64'(wbresp_val), 64'd1);
        chk("low_data", 64'(wbresp_msg_data), 64'hFFFFFFF6);
        chk("low_last", 64'(wbresp_msg_last), 64'd1);
        drain();

        // Pair split on consecutive cycles
        send(64'h12345678_9ABCDEF0, 2'b10, st);
        idle();
        #3;
        chk("pair_w0", 64'({wbresp_val, wbresp_msg_last, wbresp_msg_data}), 64'h2_9ABCDEF0);
        @(negedge clk);
        #3;
        chk("pair_w1", 64'({wbresp_val, wbresp_msg_last, wbresp_msg_data}), 64'h3_12345678);
        drain();

        // fn = 11 behaves as 10; fn = 01 gives the high word only
        send(64'hFFFFFFFF_00000001, 2'b11, st);
        idle();
        #3;
        chk("fn11_w0", 64'({wbresp_msg_last, wbresp_msg_data}), 64'h0_00000001);
        drain();
        send(64'hCAFEBABE_DEADBEEF, 2'b01, st);
        idle();
        drain();

        // Throughput: single-word results every cycle, pairs every other cycle
        for (int i = 0; i < 6; i++) begin
            send({$urandom, $urandom}, 2'($urandom_range(0, 1)), st);
            chk("tput_single", 64'(st), 64'd0);
        end
        idle();
        drain();
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 2'($urandom_range(2, 3)), st);
            chk("tput_pair", 64'(st), 64'd0);
            idle();
        end
        drain();

        // Backpressure: fill, hold, release
        @(negedge clk);
        wbresp_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v[i] = {$urandom, $urandom};
            send(v[i], 2'b00, st);
        end
        idle();
        #3;
        chk("bp_full_rdy", 64'(mulresp_rdy), 64'd0);
        chk("bp_val", 64'(wbresp_val), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            chk("bp_hold", 64'({wbresp_msg_last, wbresp_msg_data}), {31'd0, 1'b1, v[0][31:0]});
        end
        @(negedge clk);
        wbresp_rdy = 1'b1;
        @(negedge clk);
        #3;
        chk("bp_rdy_after_pop", 64'(mulresp_rdy), 64'd1);
        drain();

        // Full with simultaneous pop: the blocked result lands one cycle later
        @(negedge clk);
        wbresp_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) send({$urandom, $urandom}, 2'b00, st);
        @(negedge clk);
        wbresp_rdy         = 1'b1;
        mulresp_val        = 1'b1;
        mulresp_msg_result = 64'h55AA55AA_0BADF00D;
        mulresp_msg_fn     = 2'b01;
        #3;
        chk("full_blk_rdy", 64'(mulresp_rdy), 64'd0);
        @(negedge clk);
        #3;
        chk("full_pop_rdy", 64'(mulresp_rdy), 64'd1);
        idle();
        drain();

        // Reset while in WORD1, then accept immediately after deassertion
        @(negedge clk);
        wbresp_rdy = 1'b0;
        send(64'hAAAA5555_0F0F0F0F, 2'b10, st);
        idle();
        wbresp_rdy = 1'b1;
        #3;
        chk("w1_low", 64'({wbresp_msg_last, wbresp_msg_data}), 64'h0_0F0F0F0F);
        @(negedge clk);
        wbresp_rdy = 1'b0;
        #3;
        chk("w1_high", 64'({wbresp_val, wbresp_msg_last, wbresp_msg_data}), 64'h3_AAAA5555);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #3;
            chk("w1_hold", 64'(wbresp_msg_data), 64'hAAAA5555);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rst_async_val", 64'(wbresp_val), 64'd0);
        chk("rst_async_rdy", 64'(mulresp_rdy), 64'd1);
        @(negedge clk);
        wbresp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        mulresp_val        = 1'b1;
        mulresp_msg_result = 64'h11112222_33334444;
        mulresp_msg_fn     = 2'b00;
        #1;
        reset = 1'b0;
        #2;
        chk("post_rst_rdy", 64'(mulresp_rdy), 64'd1);
        @(posedge clk);
        idle();
        #3;
        chk("post_rst_word", 64'({wbresp_val, wbresp_msg_last, wbresp_msg_data}), 64'h3_33334444);
        drain();

        // Random traffic with random backpressure
        acc = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            wbresp_rdy = ($urandom_range(0, 3) != 0);
            if (!mulresp_val || acc) begin
                mulresp_val        = (i < 100) && ($urandom_range(0, 2) != 0);
                mulresp_msg_result = {$urandom, $urandom};
                mulresp_msg_fn     = 2'($urandom_range(0, 3));
            end
            #3;
            acc = mulresp_val && mulresp_rdy;
        end
        @(negedge clk);
        mulresp_val = 1'b0;
        wbresp_rdy  = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
